adc_frame_pkt: RTL
==================

ADC_FRAME_PKT -- requirements
Module: adc_frame_pkt

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CH_NUM, 8: channel count, 1..16.
- DATA_W, 16: sample width, a multiple of 8 in 8..32.
- HDR_BYTE, 8'h55: frame preamble.
- CMD_ID, 8'h05: command byte.
- TIMEOUT_CYC, 1000: maximum wait for a sample, in cycles, at least 1.

REQ-002 The ports SHALL be (name, direction, width, meaning):
- i_clk, in, 1: the single clock.
- i_rst, in, 1: reset, synchronous and active-high.
- i_sample_data, in, CH_NUM*DATA_W: all channel samples; channel k (1-based) occupies bits [k*DATA_W-1 : (k-1)*DATA_W].
- i_sample_valid, in, 1: one-cycle strobe; all channels are valid in that cycle.
- i_ch_mask, in, CH_NUM: channel enable; bit k-1 enables channel k.
- i_cap_seek, in, 1: one-cycle capture request.
- o_data, out, 8: frame byte.
- o_valid, out, 1: o_data is valid.
- i_ready, in, 1: the sink accepts the byte.
- o_last, out, 1: final byte of the frame.
- o_len, out, 8: total frame length in bytes, valid while o_valid is high.
- o_busy, out, 1: the state is not IDLE.
- o_timeout, out, 1: one-cycle pulse when the sample wait expires.
- o_seek_drop, out, 1: one-cycle pulse when a seek arrives while busy.

Function
REQ-003 The state machine SHALL have the states IDLE, WAIT_SMP and SEND.

REQ-004 In IDLE, i_cap_seek=1 SHALL latch i_ch_mask, clear the timeout counter and enter WAIT_SMP on the next cycle.

REQ-005 In WAIT_SMP, i_sample_valid=1 SHALL latch i_sample_data, enter SEND, and present the HDR_BYTE byte with o_valid=1 on the next cycle.

REQ-006 i_sample_valid received in IDLE or SEND SHALL be ignored.

REQ-007 In WAIT_SMP, the timeout counter SHALL increment each cycle. Once TIMEOUT_CYC cycles elapse without i_sample_valid, the block SHALL pulse o_timeout for one cycle, return to IDLE, and emit no frame.

REQ-008 The frame byte order SHALL be:
- HDR_BYTE, CMD_ID, LEN;
- then, for each enabled channel in ascending order: the channel number (1-based), followed by DATA_W/8 sample bytes, MSB first;
- then CHK.

REQ-009 LEN SHALL equal popcount(mask)*(1+DATA_W/8), computed in 8 bits; the parameter limits guarantee LEN ≤ 80.

REQ-010 o_len SHALL equal LEN+4.

REQ-011 CHK SHALL be the 8-bit XOR of CMD_ID, LEN and every payload byte; HDR_BYTE is excluded.

REQ-012 A zero mask SHALL produce the 4-byte frame HDR, CMD, 8'h00, CHK.

REQ-013 Handshake: a byte transfers when o_valid=1 and i_ready=1. While i_ready=0, o_data, o_last and o_len SHALL hold stable.

REQ-014 o_valid SHALL remain high from the first byte through the last byte, with no gaps, whenever i_ready stays high. Throughput SHALL be 1 byte per cycle.

REQ-015 o_last SHALL be high only with the CHK byte.

REQ-016 After the CHK byte transfers, o_valid SHALL be 0 on the next cycle and the state SHALL return to IDLE. A new seek is accepted from that IDLE cycle.

REQ-017 i_cap_seek in WAIT_SMP or SEND SHALL pulse o_seek_drop for one cycle and be otherwise ignored.

REQ-018 i_cap_seek together with i_rst SHALL be ignored.

REQ-019 Changes to i_ch_mask or i_sample_data after their latch point SHALL not affect the frame in progress.

REQ-020 The block SHALL not use a FIFO. A latched sample register plus a byte index counter SHALL serialise the frame.

Reset
REQ-021 i_rst=1 SHALL, on the next i_clk edge:
- force IDLE;
- set o_data, o_valid, o_last, o_len, o_busy, o_timeout and o_seek_drop to 0;
- clear the counters and latches.

REQ-022 Reset in mid-frame SHALL abandon the frame; no partial-frame resumption occurs after reset.

Verification
REQ-023 The bench SHALL cover these scenarios (all use CH_NUM=8, DATA_W=16):
- Mask 8'h05, ch1=16'h1234, ch3=16'hABCD, i_ready always 1 -> bytes 55 05 06 01 12 34 03 AB CD 41; o_len=10; o_last on 41.
- Mask 8'h00 -> bytes 55 05 00 05; o_len=4.
- Frame from the first scenario with i_ready toggled 1-0-1-0 -> same 10 bytes; o_data holds stable during every i_ready=0 cycle.
- TIMEOUT_CYC=20, seek with no sample -> o_timeout pulse; o_busy=0; no o_valid.
- Seek repeated during SEND -> o_seek_drop=1 for one cycle; current frame unchanged.
- i_rst asserted at byte 5 -> o_valid=0 next cycle; a following seek plus sample yields a full correct frame.

Source files
------------

// File: rtl/adc_frame_pkt.sv
`default_nettype none
// ============================================================================
// adc_frame_pkt : captures one multi-channel ADC sample set on request and
//                 serialises it as a byte frame HDR,CMD,LEN,{ch,bytes}*,CHK.
// Revision      : 1.0
// ============================================================================
module adc_frame_pkt #(
  parameter int          CH_NUM      = 8,
  parameter int          DATA_W      = 16,
  parameter logic [7:0]  HDR_BYTE    = 8'h55,
  parameter logic [7:0]  CMD_ID      = 8'h05,
  parameter int          TIMEOUT_CYC = 1000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [CH_NUM*DATA_W-1:0] i_sample_data,
  input  logic                     i_sample_valid,
  input  logic [CH_NUM-1:0]        i_ch_mask,
  input  logic                     i_cap_seek,
  output logic [7:0]               o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_last,
  output logic [7:0]               o_len,
  output logic                     o_busy,
  output logic                     o_timeout,
  output logic                     o_seek_drop
);

  localparam int             c_NB   = DATA_W / 8;
  localparam int             c_TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SMP, S_SEND} state_t;

  state_t                     r_state;
  logic [CH_NUM-1:0]          r_mask;
  logic [CH_NUM*DATA_W-1:0]   r_data;
  logic [c_TW-1:0]            r_tcnt;
  logic [7:0]                 r_idx;

  logic [7:0]                 w_cnt;
  logic [7:0]                 w_len;
  logic [7:0]                 w_chk;
  logic [7:0]                 w_byte;
  int                         w_pos;

  assign o_busy = (r_state != S_IDLE);

  always_comb begin
    w_cnt = 8'h00;
    w_chk = 8'h00;
    for (int k = 0; k < CH_NUM; k++) begin
      w_cnt = w_cnt + 8'(r_mask[k]);
      if (r_mask[k]) begin
        w_chk = w_chk ^ 8'(k + 1);
        for (int b = 0; b < c_NB; b++)
          w_chk = w_chk ^ r_data[(k+1)*DATA_W-1-8*b -: 8];
      end
    end
    w_len = w_cnt * 8'(c_NB + 1);
    w_chk = w_chk ^ CMD_ID ^ w_len;
  end

  // Byte r_idx of the frame, decoded from the latched mask and samples.
  always_comb begin
    w_byte = 8'h00;
    w_pos  = 3;
    for (int k = 0; k < CH_NUM; k++) begin
      if (r_mask[k]) begin
        if (int'(r_idx) == w_pos)
          w_byte = 8'(k + 1);
        for (int b = 0; b < c_NB; b++)
          if (int'(r_idx) == w_pos + 1 + b)
            w_byte = r_data[(k+1)*DATA_W-1-8*b -: 8];
        w_pos = w_pos + c_NB + 1;
      end
    end
    if (r_idx == 8'd1)
      w_byte = CMD_ID;
    if (r_idx == 8'd2)
      w_byte = w_len;
    if (r_idx == o_len - 8'd1)
      w_byte = w_chk;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_data      <= '0;
      r_tcnt      <= '0;
      r_idx       <= 8'h00;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_len       <= 8'h00;
      o_timeout   <= 1'b0;
      o_seek_drop <= 1'b0;
    end else begin
      o_timeout   <= 1'b0;
      o_seek_drop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cap_seek) begin
            r_mask  <= i_ch_mask;
            r_tcnt  <= '0;
            r_state <= S_WAIT_SMP;
          end
        end
        S_WAIT_SMP: begin
          o_seek_drop <= i_cap_seek;
          if (i_sample_valid) begin
            r_data  <= i_sample_data;
            r_idx   <= 8'd1;
            o_data  <= HDR_BYTE;
            o_valid <= 1'b1;
            o_last  <= 1'b0;
            o_len   <= w_len + 8'd4;
            r_state <= S_SEND;
          end else if (r_tcnt == c_TMAX) begin
            o_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_SEND: begin
          o_seek_drop <= i_cap_seek;
          if (o_valid && i_ready) begin
            if (o_last) begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              o_data  <= 8'h00;
              o_len   <= 8'h00;
              r_state <= S_IDLE;
            end else begin
              o_data <= w_byte;
              o_last <= (r_idx == o_len - 8'd1);
              r_idx  <= r_idx + 8'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
